// File: rtl/udp_tx_stream_arb.sv
// Packet-granular round-robin arbiter that merges NUM_SRC UDP TX header/data
// streams onto the single udp_to_stream input: header first, then data through last.
module udp_tx_stream_arb #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned DATA_W  = 512,
  parameter int unsigned PAD_W   = 6,
  parameter int unsigned TS_W    = 64,
  parameter int unsigned SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        src_hdr_val,
  input  logic [NUM_SRC*32-1:0]     src_src_ip,
  input  logic [NUM_SRC*32-1:0]     src_dst_ip,
  input  logic [NUM_SRC*64-1:0]     src_udp_hdr,
  input  logic [NUM_SRC*TS_W-1:0]   src_timestamp,
  output logic [NUM_SRC-1:0]        src_hdr_rdy,
  input  logic [NUM_SRC-1:0]        src_data_val,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]        src_data_last,
  input  logic [NUM_SRC*PAD_W-1:0]  src_data_padbytes,
  output logic [NUM_SRC-1:0]        src_data_rdy,
  output logic                      arb_hdr_val,
  output logic [31:0]               arb_src_ip,
  output logic [31:0]               arb_dst_ip,
  output logic [63:0]               arb_udp_hdr,
  output logic [TS_W-1:0]           arb_timestamp,
  input  logic                      dst_hdr_rdy,
  output logic                      arb_data_val,
  output logic [DATA_W-1:0]         arb_data,
  output logic                      arb_data_last,
  output logic [PAD_W-1:0]          arb_data_padbytes,
  input  logic                      dst_data_rdy,
  output logic                      arb_busy,
  output logic [SRC_W-1:0]          arb_cur_src,
  output logic [31:0]               arb_pkt_cnt
);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t             state, state_nxt;
  logic [SRC_W-1:0]   cur_src, cur_src_nxt;
  logic [SRC_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [SRC_W-1:0]   grant;
  logic               grant_found;
  logic               pkt_done;
  logic [31:0]        pkt_cnt;

  logic               sel_hdr_val;
  logic [31:0]        sel_src_ip;
  logic [31:0]        sel_dst_ip;
  logic [63:0]        sel_udp_hdr;
  logic [TS_W-1:0]    sel_timestamp;
  logic               sel_data_val;
  logic [DATA_W-1:0]  sel_data;
  logic               sel_data_last;
  logic [PAD_W-1:0]   sel_data_padbytes;

  always_comb begin
    sel_hdr_val       = 1'b0;
    sel_src_ip        = '0;
    sel_dst_ip        = '0;
    sel_udp_hdr       = '0;
    sel_timestamp     = '0;
    sel_data_val      = 1'b0;
    sel_data          = '0;
    sel_data_last     = 1'b0;
    sel_data_padbytes = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (SRC_W'(i) == cur_src) begin
        sel_hdr_val       = src_hdr_val[i];
        sel_src_ip        = src_src_ip[i*32 +: 32];
        sel_dst_ip        = src_dst_ip[i*32 +: 32];
        sel_udp_hdr       = src_udp_hdr[i*64 +: 64];
        sel_timestamp     = src_timestamp[i*TS_W +: TS_W];
        sel_data_val      = src_data_val[i];
        sel_data          = src_data[i*DATA_W +: DATA_W];
        sel_data_last     = src_data_last[i];
        sel_data_padbytes = src_data_padbytes[i*PAD_W +: PAD_W];
      end
    end
  end

  // Round-robin search in two passes: requesters at/above rr_ptr first, then wrap.
  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (!grant_found && src_hdr_val[i] && (SRC_W'(i) >= rr_ptr)) begin
        grant       = SRC_W'(i);
        grant_found = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (!grant_found && src_hdr_val[i]) begin
        grant       = SRC_W'(i);
        grant_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cur_src <= '0;
      rr_ptr  <= '0;
      pkt_cnt <= '0;
    end else begin
      state   <= state_nxt;
      cur_src <= cur_src_nxt;
      rr_ptr  <= rr_ptr_nxt;
      if (pkt_done) pkt_cnt <= pkt_cnt + 32'd1;
    end
  end

  always_comb begin
    state_nxt   = state;
    cur_src_nxt = cur_src;
    rr_ptr_nxt  = rr_ptr;
    pkt_done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant_found) begin
          cur_src_nxt = grant;
          state_nxt   = HDR;
        end
      end
      HDR: begin
        if (sel_hdr_val && dst_hdr_rdy) state_nxt = DATA;
      end
      DATA: begin
        if (sel_data_val && dst_data_rdy && sel_data_last) begin
          state_nxt  = IDLE;
          pkt_done   = 1'b1;
          rr_ptr_nxt = (32'(cur_src) == NUM_SRC - 1) ? '0 : cur_src + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    src_hdr_rdy  = '0;
    src_data_rdy = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (SRC_W'(i) == cur_src) begin
        src_hdr_rdy[i]  = (state == HDR) && dst_hdr_rdy;
        src_data_rdy[i] = (state == DATA) && dst_data_rdy;
      end
    end
    arb_hdr_val  = (state == HDR) && sel_hdr_val;
    arb_data_val = (state == DATA) && sel_data_val;
    arb_busy     = (state != IDLE);
  end

  assign arb_src_ip        = sel_src_ip;
  assign arb_dst_ip        = sel_dst_ip;
  assign arb_udp_hdr       = sel_udp_hdr;
  assign arb_timestamp     = sel_timestamp;
  assign arb_data          = sel_data;
  assign arb_data_last     = sel_data_last;
  assign arb_data_padbytes = sel_data_padbytes;
  assign arb_cur_src       = cur_src;
  assign arb_pkt_cnt       = pkt_cnt;

endmodule

// File: tb/tb_udp_tx_stream_arb.sv
// Randomized producers feed per-source expected queues; a monitor tracks the
// arbitration rules at packet level and compares every handshake against them.
module tb_udp_tx_stream_arb;
  localparam int NS = 4;
  localparam int DW = 64;
  localparam int PW = 6;
  localparam int TW = 64;
  localparam int SW = 2;

  typedef struct packed {
    logic [31:0]   sip;
    logic [31:0]   dip;
    logic [63:0]   uh;
    logic [TW-1:0] ts;
  } hdr_t;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          last;
    logic [PW-1:0] pad;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NS-1:0]     src_hdr_val;
  logic [NS*32-1:0]  src_src_ip;
  logic [NS*32-1:0]  src_dst_ip;
  logic [NS*64-1:0]  src_udp_hdr;
  logic [NS*TW-1:0]  src_timestamp;
  logic [NS-1:0]     src_hdr_rdy;
  logic [NS-1:0]     src_data_val;
  logic [NS*DW-1:0]  src_data;
  logic [NS-1:0]     src_data_last;
  logic [NS*PW-1:0]  src_data_padbytes;
  logic [NS-1:0]     src_data_rdy;
  logic              arb_hdr_val;
  logic [31:0]       arb_src_ip;
  logic [31:0]       arb_dst_ip;
  logic [63:0]       arb_udp_hdr;
  logic [TW-1:0]     arb_timestamp;
  logic              dst_hdr_rdy;
  logic              arb_data_val;
  logic [DW-1:0]     arb_data;
  logic              arb_data_last;
  logic [PW-1:0]     arb_data_padbytes;
  logic              dst_data_rdy;
  logic              arb_busy;
  logic [SW-1:0]     arb_cur_src;
  logic [31:0]       arb_pkt_cnt;

  udp_tx_stream_arb #(
    .NUM_SRC(NS),
    .DATA_W (DW),
    .PAD_W  (PW),
    .TS_W   (TW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .src_hdr_val      (src_hdr_val),
    .src_src_ip       (src_src_ip),
    .src_dst_ip       (src_dst_ip),
    .src_udp_hdr      (src_udp_hdr),
    .src_timestamp    (src_timestamp),
    .src_hdr_rdy      (src_hdr_rdy),
    .src_data_val     (src_data_val),
    .src_data         (src_data),
    .src_data_last    (src_data_last),
    .src_data_padbytes(src_data_padbytes),
    .src_data_rdy     (src_data_rdy),
    .arb_hdr_val      (arb_hdr_val),
    .arb_src_ip       (arb_src_ip),
    .arb_dst_ip       (arb_dst_ip),
    .arb_udp_hdr      (arb_udp_hdr),
    .arb_timestamp    (arb_timestamp),
    .dst_hdr_rdy      (dst_hdr_rdy),
    .arb_data_val     (arb_data_val),
    .arb_data         (arb_data),
    .arb_data_last    (arb_data_last),
    .arb_data_padbytes(arb_data_padbytes),
    .dst_data_rdy     (dst_data_rdy),
    .arb_busy         (arb_busy),
    .arb_cur_src      (arb_cur_src),
    .arb_pkt_cnt      (arb_pkt_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  hdr_t  exp_hdr  [NS][$];
  beat_t exp_beat [NS][$];

  int unsigned budget [NS];
  int unsigned dphase [NS];
  int unsigned beats_left [NS];
  int unsigned start_pct = 100;
  int unsigned beat_pct = 100;
  int unsigned hdr_pct = 100;
  int unsigned data_pct = 100;
  int unsigned min_beats = 1;
  int unsigned max_beats = 1;
  bit          data_toggle = 1'b0;

  int mon_phase = 0;
  int beats_seen = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Winner is the first requester at or after the pointer, wrapping around.
  function automatic int pick(input int rr, input logic [NS-1:0] req);
    int j;
    for (int k = 0; k < NS; k++) begin
      j = (rr + k) % NS;
      if (req[j]) return j;
    end
    return 0;
  endfunction

  task automatic present_beat(input int i);
    beat_t b;
    b.d    = {$urandom, $urandom};
    b.last = (beats_left[i] == 1);
    b.pad  = PW'($urandom);
    exp_beat[i].push_back(b);
    src_data[i*DW +: DW]          = b.d;
    src_data_last[i]              = b.last;
    src_data_padbytes[i*PW +: PW] = b.pad;
    src_data_val[i]               = 1'b1;
    beats_left[i]--;
  endtask

  task automatic start_packet(input int i);
    hdr_t h;
    h.sip = {8'(i), 24'($urandom)};
    h.dip = $urandom;
    h.uh  = {$urandom, $urandom};
    h.ts  = {$urandom, $urandom};
    exp_hdr[i].push_back(h);
    src_src_ip[i*32 +: 32]    = h.sip;
    src_dst_ip[i*32 +: 32]    = h.dip;
    src_udp_hdr[i*64 +: 64]   = h.uh;
    src_timestamp[i*TW +: TW] = h.ts;
    src_hdr_val[i] = 1'b1;
    dphase[i]      = 1;
    beats_left[i]  = $urandom_range(max_beats, min_beats);
    budget[i]--;
  endtask

  task automatic clear_producers();
    for (int i = 0; i < NS; i++) begin
      src_hdr_val[i]  = 1'b0;
      src_data_val[i] = 1'b0;
      dphase[i]       = 0;
      beats_left[i]   = 0;
      budget[i]       = 0;
      exp_hdr[i].delete();
      exp_beat[i].delete();
    end
  endtask

  initial begin : driver
    logic [NS-1:0] hf, df;
    forever begin
      @(negedge clk);
      hf = src_hdr_val & src_hdr_rdy;
      df = src_data_val & src_data_rdy;
      @(posedge clk);
      #1;
      if (!rst) continue;
      for (int i = 0; i < NS; i++) begin
        if (hf[i]) begin
          src_hdr_val[i] = 1'b0;
          dphase[i] = 2;
        end
        if (df[i]) begin
          src_data_val[i] = 1'b0;
          if (beats_left[i] == 0) dphase[i] = 0;
        end
        if (dphase[i] == 0) begin
          if (budget[i] > 0 && $urandom_range(99) < start_pct) start_packet(i);
        end else if (!src_data_val[i] && beats_left[i] > 0 && $urandom_range(99) < beat_pct) begin
          present_beat(i);
        end
      end
      dst_hdr_rdy  = ($urandom_range(99) < hdr_pct);
      dst_data_rdy = data_toggle ? ~dst_data_rdy : ($urandom_range(99) < data_pct);
    end
  end

  initial begin : monitor
    int rr;
    int exp_src;
    logic [31:0] cnt_m;
    logic [NS-1:0] onehot;
    hdr_t h;
    beat_t b;
    rr = 0; exp_src = 0; cnt_m = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mon_phase = 0; rr = 0; exp_src = 0; cnt_m = '0;
        continue;
      end
      onehot = NS'(1) << exp_src;
      case (mon_phase)
        0: begin
          chk("idle_quiet", {arb_hdr_val, arb_data_val, src_hdr_rdy, src_data_rdy, arb_busy}, '0);
          chk("idle_pkt_cnt", arb_pkt_cnt, cnt_m);
          chk("idle_cur_src_hold", arb_cur_src, exp_src);
          if (|src_hdr_val) begin
            exp_src = pick(rr, src_hdr_val);
            mon_phase = 1;
          end
        end
        1: begin
          chk("hdr_busy", arb_busy, 1);
          chk("hdr_grant", arb_cur_src, exp_src);
          chk("hdr_val", arb_hdr_val, src_hdr_val[exp_src]);
          chk("hdr_rdy_route", src_hdr_rdy, dst_hdr_rdy ? onehot : '0);
          chk("hdr_no_data", {arb_data_val, src_data_rdy}, '0);
          if (arb_hdr_val && dst_hdr_rdy) begin
            checks++;
            if (exp_hdr[exp_src].size() == 0) begin
              failures++;
              $display("FAIL hdr_unexpected src=%0d sip=%0h", exp_src, arb_src_ip);
            end else begin
              h = exp_hdr[exp_src].pop_front();
              chk("hdr_src_ip", arb_src_ip, h.sip);
              chk("hdr_dst_ip", arb_dst_ip, h.dip);
              chk("hdr_udp_hdr", arb_udp_hdr, h.uh);
              chk("hdr_timestamp", arb_timestamp, h.ts);
            end
            mon_phase = 2;
          end
        end
        default: begin
          chk("data_busy", arb_busy, 1);
          chk("data_grant", arb_cur_src, exp_src);
          chk("data_val", arb_data_val, src_data_val[exp_src]);
          chk("data_rdy_route", src_data_rdy, dst_data_rdy ? onehot : '0);
          chk("data_no_hdr", {arb_hdr_val, src_hdr_rdy}, '0);
          if (arb_data_val && dst_data_rdy) begin
            beats_seen++;
            checks++;
            if (exp_beat[exp_src].size() == 0) begin
              failures++;
              $display("FAIL beat_unexpected src=%0d data=%0h", exp_src, arb_data);
            end else begin
              b = exp_beat[exp_src].pop_front();
              chk("beat_data", arb_data, b.d);
              chk("beat_last", arb_data_last, b.last);
              chk("beat_pad", arb_data_padbytes, b.pad);
            end
            if (arb_data_last) begin
              cnt_m++;
              rr = (exp_src + 1) % NS;
              mon_phase = 0;
            end
          end
        end
      endcase
    end
  end

  task automatic wait_drain(input string nm, input int limit);
    int n;
    bit done;
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
      done = (mon_phase == 0);
      for (int i = 0; i < NS; i++)
        if (budget[i] != 0 || dphase[i] != 0) done = 1'b0;
    end while (!done && n < limit);
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s drain_timeout cycles=%0d required<%0d", nm, n, limit);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic set_mode(input int unsigned sp, bp, hp, dp, mn, mx, input bit tog);
    start_pct = sp; beat_pct = bp; hdr_pct = hp; data_pct = dp;
    min_beats = mn; max_beats = mx; data_toggle = tog;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_outputs_zero", {arb_hdr_val, arb_data_val, src_hdr_rdy, src_data_rdy, arb_busy}, '0);
    chk("rst_pkt_cnt", arb_pkt_cnt, 0);
    chk("rst_cur_src", arb_cur_src, 0);
    clear_producers();
    repeat (2) @(negedge clk);
    #3 rst = 1'b1;
  endtask

  initial begin : main
    int base;
    int unsigned exp_total;
    rst = 1'b0;
    src_hdr_val = '0; src_src_ip = '0; src_dst_ip = '0; src_udp_hdr = '0;
    src_timestamp = '0; src_data_val = '0; src_data = '0; src_data_last = '0;
    src_data_padbytes = '0; dst_hdr_rdy = 1'b0; dst_data_rdy = 1'b1;
    for (int i = 0; i < NS; i++) begin budget[i] = 0; dphase[i] = 0; beats_left[i] = 0; end
    exp_total = 0;

    #13;
    chk("reset_quiet", {arb_hdr_val, arb_data_val, src_hdr_rdy, src_data_rdy, arb_busy}, '0);
    chk("reset_pkt_cnt", arb_pkt_cnt, 0);
    @(negedge clk);
    #3 rst = 1'b1;

    // single source, 3 beats, always ready
    set_mode(100, 100, 100, 100, 3, 3, 1'b0);
    budget[2] = 1; exp_total += 1;
    wait_drain("t1_single", 200);
    chk("t1_pkt_cnt", arb_pkt_cnt, exp_total);
    chk("t1_busy_low", arb_busy, 0);

    // all four at once from a fresh pointer: order 0,1,2,3
    pulse_reset(); exp_total = 0;
    set_mode(100, 100, 100, 100, 1, 1, 1'b0);
    for (int i = 0; i < NS; i++) budget[i] = 1;
    exp_total += 4;
    wait_drain("t2_all", 300);
    chk("t2_pkt_cnt", arb_pkt_cnt, exp_total);

    // pointer wrapped past 3: sources 0 and 3 together, 0 wins
    budget[0] = 1; budget[3] = 1; exp_total += 2;
    wait_drain("t3_wrap", 300);
    chk("t3_pkt_cnt", arb_pkt_cnt, exp_total);

    // toggling data ready on a 4-beat packet from source 1
    set_mode(100, 100, 100, 100, 4, 4, 1'b1);
    budget[1] = 1; exp_total += 1;
    wait_drain("t4_toggle", 300);
    chk("t4_pkt_cnt", arb_pkt_cnt, exp_total);

    // header stalled with data already offered: no data_rdy before hdr handshake
    set_mode(100, 100, 0, 100, 2, 2, 1'b0);
    budget[2] = 1; exp_total += 1;
    repeat (2) @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #2;
      chk("t5_no_data_rdy", src_data_rdy[2], 0);
      chk("t5_hdr_held", src_hdr_val[2], 1);
    end
    hdr_pct = 100;
    wait_drain("t5_hdr_stall", 300);
    chk("t5_pkt_cnt", arb_pkt_cnt, exp_total);

    // random traffic
    set_mode(30, 75, 70, 60, 1, 4, 1'b0);
    for (int i = 0; i < NS; i++) budget[i] = 12;
    exp_total += 12 * NS;
    wait_drain("t6_random", 20000);
    chk("t6_pkt_cnt", arb_pkt_cnt, exp_total);

    // reset on beat 2 of 4, then pointer restarts at 0
    set_mode(100, 100, 100, 100, 4, 4, 1'b0);
    budget[1] = 1;
    base = beats_seen;
    for (int c = 0; c < 200 && beats_seen < base + 1; c++) @(negedge clk);
    chk("t7_first_beat_seen", 32'(beats_seen - base), 1);
    pulse_reset(); exp_total = 0;
    budget[2] = 1; budget[0] = 1; exp_total += 2;
    wait_drain("t7_after_reset", 300);
    chk("t7_pkt_cnt", arb_pkt_cnt, exp_total);

    for (int i = 0; i < NS; i++) begin
      chk("final_hdr_q_empty", exp_hdr[i].size(), 0);
      chk("final_beat_q_empty", exp_beat[i].size(), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/udp_tx_stream_arb.md
Name: udp_tx_stream_arb

Overview:
- Packet-granular round-robin arbiter that shares one udp_to_stream header/data input between NUM_SRC independent UDP TX producers, e.g. several udp_tx_noc_in front-ends.
- Grants one source, forwards that source's header, then its data beats through the last beat, then re-arbitrates.
- Sits between the producers and udp_to_stream inside a multi-producer UDP TX tile.

Parameters:
- NUM_SRC, 4, number of requesting producers (≥1).
- DATA_W, 512, data beat width (MAC_INTERFACE_W).
- PAD_W, 6, padbytes width (MAC_PADBYTES_W).
- TS_W, 64, timestamp width (MSG_TIMESTAMP_W).
- SRC_W, max(1,$clog2(NUM_SRC)), source index width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- src_hdr_val  in  NUM_SRC  per-source header valid.
- src_src_ip  in  NUM_SRC*32  per-source source IP, source i at [i*32 +: 32].
- src_dst_ip  in  NUM_SRC*32  per-source destination IP.
- src_udp_hdr  in  NUM_SRC*64  per-source udp_pkt_hdr.
- src_timestamp  in  NUM_SRC*TS_W  per-source timestamp.
- src_hdr_rdy  out  NUM_SRC  per-source header ready.
- src_data_val  in  NUM_SRC  per-source data valid.
- src_data  in  NUM_SRC*DATA_W  per-source data.
- src_data_last  in  NUM_SRC  per-source last beat.
- src_data_padbytes  in  NUM_SRC*PAD_W  per-source padbytes.
- src_data_rdy  out  NUM_SRC  per-source data ready.
- arb_hdr_val  out  1  header valid to udp_to_stream.
- arb_src_ip / arb_dst_ip  out  32 each  muxed IPs.
- arb_udp_hdr  out  64  muxed UDP header.
- arb_timestamp  out  TS_W  muxed timestamp.
- dst_hdr_rdy  in  1  header ready.
- arb_data_val  out  1  data valid.
- arb_data  out  DATA_W  data.
- arb_data_last  out  1  last beat.
- arb_data_padbytes  out  PAD_W  padbytes.
- dst_data_rdy  in  1  data ready.
- arb_busy  out  1  high in HDR or DATA.
- arb_cur_src  out  SRC_W  currently granted source.
- arb_pkt_cnt  out  32  completed packets, wraps at 2^32.

Behaviour:
- Reset (rst low, async): state=IDLE, rr_ptr=0, cur_src=0, pkt_cnt=0. All val and rdy outputs are 0 and arb_busy=0. Muxed data outputs are don't-care but driven from source 0.
- IDLE state:
  - All rdy and val outputs are 0.
  - If any src_hdr_val is set, register cur_src = first requester at or after rr_ptr, searching upward with wrap from NUM_SRC-1 to 0, and go to HDR.
  - Arbitration costs exactly 1 bubble cycle: a request seen at cycle N is presented at arb_hdr_val in cycle N+1.
- HDR state:
  - arb_hdr_val = src_hdr_val[cur_src]; header fields are muxed combinationally from cur_src.
  - src_hdr_rdy[cur_src] = dst_hdr_rdy; all other hdr_rdy are 0.
  - On arb_hdr_val && dst_hdr_rdy, go to DATA.
- DATA state:
  - arb_data_* are muxed from cur_src; src_data_rdy[cur_src] = dst_data_rdy; all other data_rdy are 0.
  - No header handshake occurs in DATA.
  - On arb_data_val && dst_data_rdy && arb_data_last: rr_ptr = cur_src+1 (wrapping to 0 after NUM_SRC-1), pkt_cnt += 1, go to IDLE.
- Non-granted sources see rdy=0 and must hold val. Their data beats and headers are never consumed or dropped.
- Producer contract:
  - val holds until its handshake.
  - Each packet has one header followed by ≥1 data beats, with exactly one last.
  - The arbiter does not re-arbitrate if the granted source stalls; stalls propagate.
- A data beat presented by the granted source while in HDR is not accepted until after the header handshake.
- Simultaneous requests are granted in round-robin order. A source requesting continuously gets at most one packet per round when others request.
- NUM_SRC=1: always grant 0; rr_ptr stays 0.
- arb_cur_src holds its last value in IDLE.
- Reset asserted mid-packet returns immediately to IDLE with pointer 0; the partial packet is abandoned, and recovery is the downstream's responsibility.

Test Plan:
- Single source 2 requests 3-beat packet, dst always ready → hdr out cycle 1 after request, 3 data beats in consecutive cycles, last on beat 3, pkt_cnt=1, arb_busy low after.
- Sources 0,1,2,3 request simultaneously, each with a 1-beat packet → grant order 0,1,2,3, pkt_cnt=4, rr_ptr back at 0.
- Source 3 finishes, then sources 0 and 3 request → source 0 granted first (wrap), then 3.
- dst_data_rdy toggled 1,0,1,0 during a 4-beat packet from source 1 → no beat duplicated or lost; source 0 data_rdy stays 0 throughout.
- Source 2 holds hdr_val and data_val together, dst_hdr_rdy low for 5 cycles → no data_rdy to source 2 until the header handshake, then data flows.
- rst pulsed low mid-packet (beat 2 of 4) → all val/rdy 0 asynchronously, pkt_cnt=0; the next request is granted from source 0.
